icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
// - Direct-mapped instruction cache between the IF stage and mem_control's instruction port.
// - Hits return the instruction one cycle after the request, with no memory traffic.
// - Misses issue one fetch to mem_control, fill the line and return the instruction.
// - Redirects on branch_interception abandon any pending miss.
// PARAMETERS
// - IDX_W   7   index bits; the cache holds 2**IDX_W one-word lines.
// - ADDR_W  17  significant PC bits; the tag is pc[ADDR_W-1:IDX_W+2].
// PORTS
// - clk                  in   1   system clock.
// - rst                  in   1   reset, asynchronous, active-low.
// - rdy                  in   1   pause; when low, all state and outputs are frozen.
// - branch_interception  in   1   pipeline redirect; kills the in-flight request.
// - if_req               in   1   IF requests the instruction at if_pc.
// - if_pc                in   32  fetch address; bits [1:0] are ignored.
// - inst_valid           out  1   inst/inst_pc are valid this cycle (single-cycle pulse).
// - inst                 out  32  instruction word.
// - inst_pc              out  32  address of inst.
// - busy                 out  1   miss in progress; IF holds if_pc stable.
// - mc_req               out  1   fetch request to mem_control.
// - mc_addr              out  32  fetch address to mem_control.
// - mc_valid             in   1   mem_control returns a word.
// - mc_inst              in   32  returned word.
// - mc_addr_back         in   32  address of the returned word.
// BEHAVIOUR
// - Reset (rst=0, async): all line valid bits=0, state=IDLE, inst_valid=0, inst=0, inst_pc=0, busy=0, mc_req=0, mc_addr=0.
// - Lookup: idx=if_pc[IDX_W+1:2], tag=if_pc[ADDR_W-1:IDX_W+2].
// - Uncacheable: if_pc[17:16]==2'b11 (I/O) is treated as a miss and never filled.
// - IDLE, if_req and hit:
//   - next cycle: inst_valid=1, inst=line data, inst_pc=if_pc; state stays IDLE.
//   - Back-to-back hits sustain one instruction per cycle.
// - IDLE, if_req and miss:
//   - next cycle: state=MISS, busy=1, mc_req=1, mc_addr={if_pc[31:2],2'b00}; the address is latched.
// - MISS: mc_req is held high until mc_valid=1 with mc_addr_back==latched address.
//   - On that cycle: write data, tag and valid (unless uncacheable); mc_req=0.
//   - Next cycle: inst_valid=1, inst=mc_inst, inst_pc=latched address, busy=0, state=IDLE.
// - mc_valid outside MISS, or with a mismatched mc_addr_back: ignored, no fill.
// - branch_interception=1 (any state, highest priority after reset):
//   - next cycle: state=IDLE, inst_valid=0, busy=0, mc_req=0; cache contents are kept.
//   - if_req in the same cycle is ignored.
//   - A fill whose mc_valid coincides with the branch still writes the line, but inst_valid stays 0.
// - rdy=0: no state or array update, outputs hold, mc_valid is ignored. mem_control obeys the same rdy.
// - inst_valid is a one-cycle pulse; IF re-requests to get the next word.
// - Array: 2**IDX_W x (32 data + tag + 1 valid bits), synchronous write; the read is combinational into the output register.
// CONFIGURATION
// - Macro ICACHE_STAT_EN.
// - Defined:
//   - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], both reset to 0.
//   - hit_cnt +1 on each accepted hit; miss_cnt +1 on each IDLE->MISS transition.
//   - Both are frozen when rdy=0 and wrap modulo 2**32.
// - Undefined: the ports and counters are absent; behaviour is otherwise identical.
// TESTING
// - Cold miss:
//   - Stimulus: after reset, if_req with if_pc=0x0000_1000.
//   - Response: mc_req=1 and mc_addr=0x1000 next cycle.
//   - Then mc_valid with mc_inst=0x0000_0013 and mc_addr_back=0x1000 -> inst_valid=1, inst=0x13, inst_pc=0x1000 next cycle.
// - Hit: re-request 0x1000 -> inst_valid=1 one cycle later with inst=0x13, mc_req stays 0.
// - Conflict: request 0x1200 (same idx, IDX_W=7) -> miss and fill; a following request to 0x1000 misses again.
// - Redirect: branch_interception during MISS for 0x2000, then mc_valid for 0x2000 -> inst_valid stays 0, busy=0.
//   A later request to 0x2000 misses (the line was not filled).
// - Stale and I/O: mc_valid with mc_addr_back=0x3000 while MISS for 0x4000 -> ignored, mc_req stays 1.
//   Fetch at 0x30000 -> always misses, never filled.
// - Pause and reset: rdy=0 for 5 cycles during MISS -> outputs frozen, mc_valid ignored.
//   rst=0 mid-MISS -> all outputs 0 immediately; a prior hit address now misses.
//   With ICACHE_STAT_EN: 2 hits + 3 misses -> hit_cnt=2, miss_cnt=3.

Source files
------------

// File: rtl/icache.sv
// icache - direct-mapped, one-word-per-line instruction cache sitting between
// the IF stage and the instruction port of mem_control.
//
// Optional feature: define ICACHE_STAT_EN to add hit/miss statistic counters.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   rdy                      pause: when low, all state and outputs hold
//   branch_interception      pipeline redirect, abandons any pending miss
//   if_req, if_pc            fetch request from IF (if_pc[1:0] ignored)
//   inst_valid, inst,        one-cycle pulse carrying the fetched word and
//   inst_pc                  its address
//   busy                     miss in progress (IF holds if_pc stable)
//   mc_req, mc_addr          fetch request to mem_control
//   mc_valid, mc_inst,       word returned by mem_control and its address
//   mc_addr_back
//   hit_cnt, miss_cnt        (ICACHE_STAT_EN only) accepted hits / misses
module icache #(
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned ADDR_W = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        branch_interception,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        busy,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_valid,
  input  logic [31:0] mc_inst,
  input  logic [31:0] mc_addr_back
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t state_q, state_d;

  logic [DEPTH-1:0] line_valid;
  logic [31:0]      line_data [DEPTH];
  logic [TAG_W-1:0] line_tag  [DEPTH];

  logic [31:0] miss_addr_q, miss_addr_d;
  logic        inst_valid_d;
  logic [31:0] inst_d, inst_pc_d;

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_io, wr_io, hit, fill_match, fill_we;

  assign rd_idx = if_pc[IDX_W+1:2];
  assign rd_tag = if_pc[ADDR_W-1:IDX_W+2];
  assign rd_io  = (if_pc[17:16] == 2'b11);
  assign wr_idx = miss_addr_q[IDX_W+1:2];
  assign wr_tag = miss_addr_q[ADDR_W-1:IDX_W+2];
  assign wr_io  = (miss_addr_q[17:16] == 2'b11);

  // I/O space never hits, so a stale line can never shadow a device read.
  assign hit = line_valid[rd_idx] && (line_tag[rd_idx] == rd_tag) && !rd_io;

  assign fill_match = (state_q == S_MISS) && mc_valid && (mc_addr_back == miss_addr_q);
  // The fill is written even when a redirect lands on the same cycle.
  assign fill_we    = rdy && fill_match && !wr_io;

  assign busy    = (state_q == S_MISS);
  assign mc_req  = (state_q == S_MISS);
  assign mc_addr = miss_addr_q;

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    inst_valid_d = 1'b0;
    inst_d       = inst;
    inst_pc_d    = inst_pc;
    if (branch_interception) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (if_req) begin
            if (hit) begin
              inst_valid_d = 1'b1;
              inst_d       = line_data[rd_idx];
              inst_pc_d    = if_pc;
            end else begin
              state_d     = S_MISS;
              miss_addr_d = {if_pc[31:2], 2'b00};
            end
          end
        end
        S_MISS: begin
          if (fill_match) begin
            state_d      = S_IDLE;
            inst_valid_d = 1'b1;
            inst_d       = mc_inst;
            inst_pc_d    = miss_addr_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      inst_valid  <= 1'b0;
      inst        <= '0;
      inst_pc     <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      inst_valid  <= inst_valid_d;
      inst        <= inst_d;
      inst_pc     <= inst_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_valid <= '0;
    end else if (fill_we) begin
      line_valid[wr_idx] <= 1'b1;
    end
  end

  // Data and tag storage carry no reset; the valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      line_data[wr_idx] <= mc_inst;
      line_tag[wr_idx]  <= wr_tag;
    end
  end

`ifdef ICACHE_STAT_EN
  logic hit_evt, miss_evt;

  assign hit_evt  = (state_q == S_IDLE) && !branch_interception && if_req && hit;
  assign miss_evt = (state_q == S_IDLE) && !branch_interception && if_req && !hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy) begin
      if (hit_evt)  hit_cnt  <= hit_cnt + 32'd1;
      if (miss_evt) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  localparam int unsigned IDX_W  = 7;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DEPTH  = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        br  = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_pc = '0;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        busy, mc_req;
  logic [31:0] mc_addr;
  logic        mc_valid = 1'b0;
  logic [31:0] mc_inst = '0;
  logic [31:0] mc_addr_back = '0;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .branch_interception (br),
    .if_req              (if_req),
    .if_pc               (if_pc),
    .inst_valid          (inst_valid),
    .inst                (inst),
    .inst_pc             (inst_pc),
    .busy                (busy),
    .mc_req              (mc_req),
    .mc_addr             (mc_addr),
    .mc_valid            (mc_valid),
    .mc_inst             (mc_inst),
    .mc_addr_back        (mc_addr_back)
`ifdef ICACHE_STAT_EN
    ,
    .hit_cnt             (hit_cnt),
    .miss_cnt            (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a table of remembered lines plus one outstanding fetch.
  bit          m_valid [DEPTH];
  logic [31:0] m_data  [DEPTH];
  int unsigned m_tag   [DEPTH];
  bit          pend;
  logic [31:0] pend_addr;
  bit          e_valid;
  logic [31:0] e_inst, e_pc;
  int unsigned m_hits, m_misses;
  bit          m_fill;

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return (a % (1 << ADDR_W)) / (4 * DEPTH);
  endfunction

  function automatic bit is_io(input logic [31:0] a);
    return a[17:16] == 2'b11;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      pend = 1'b0; pend_addr = '0;
      e_valid = 1'b0; e_inst = '0; e_pc = '0;
      m_hits = 0; m_misses = 0;
    end else if (rdy) begin
      m_fill = pend && mc_valid && (mc_addr_back == pend_addr);
      if (m_fill && !is_io(pend_addr)) begin
        m_valid[idx_of(pend_addr)] = 1'b1;
        m_tag[idx_of(pend_addr)]   = tag_of(pend_addr);
        m_data[idx_of(pend_addr)]  = mc_inst;
      end
      e_valid = 1'b0;
      if (br) begin
        pend = 1'b0;
      end else if (pend) begin
        if (m_fill) begin
          pend = 1'b0; e_valid = 1'b1; e_inst = mc_inst; e_pc = pend_addr;
        end
      end else if (if_req) begin
        if (!is_io(if_pc) && m_valid[idx_of(if_pc)] && m_tag[idx_of(if_pc)] == tag_of(if_pc)) begin
          e_valid = 1'b1; e_inst = m_data[idx_of(if_pc)]; e_pc = if_pc; m_hits++;
        end else begin
          pend = 1'b1; pend_addr = {if_pc[31:2], 2'b00}; m_misses++;
        end
      end
    end
    #1;
    chk("m_inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
    chk("m_busy", {31'b0, busy}, {31'b0, pend});
    chk("m_mc_req", {31'b0, mc_req}, {31'b0, pend});
    if (pend) chk("m_mc_addr", mc_addr, pend_addr);
    if (e_valid) begin
      chk("m_inst", inst, e_inst);
      chk("m_inst_pc", inst_pc, e_pc);
    end
`ifdef ICACHE_STAT_EN
    chk("m_hit_cnt", hit_cnt, m_hits);
    chk("m_miss_cnt", miss_cnt, m_misses);
`endif
  end

  // Drive one request cycle; returns at the negedge after the DUT sampled it.
  task automatic req(input logic [31:0] pc);
    if_req = 1'b1; if_pc = pc;
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic resp(input logic [31:0] addr, input logic [31:0] data, input logic with_br);
    mc_valid = 1'b1; mc_addr_back = addr; mc_inst = data; br = with_br;
    @(negedge clk);
    mc_valid = 1'b0; br = 1'b0;
  endtask

  task automatic miss_fill(input logic [31:0] pc, input logic [31:0] data);
    req(pc);
    chk("fill_req", {31'b0, mc_req}, 32'd1);
    resp(pc, data, 1'b0);
    chk("fill_inst", inst, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mc_req", {31'b0, mc_req}, 32'd0);
    chk("rst_mc_addr", mc_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // cold miss
    req(32'h0000_1000);
    chk("cold_mc_req", {31'b0, mc_req}, 32'd1);
    chk("cold_mc_addr", mc_addr, 32'h0000_1000);
    chk("cold_busy", {31'b0, busy}, 32'd1);
    resp(32'h0000_1000, 32'h0000_0013, 1'b0);
    chk("cold_valid", {31'b0, inst_valid}, 32'd1);
    chk("cold_inst", inst, 32'h0000_0013);
    chk("cold_inst_pc", inst_pc, 32'h0000_1000);
    chk("cold_busy_clr", {31'b0, busy}, 32'd0);

    // hit
    req(32'h0000_1000);
    chk("hit_valid", {31'b0, inst_valid}, 32'd1);
    chk("hit_inst", inst, 32'h0000_0013);
    chk("hit_no_req", {31'b0, mc_req}, 32'd0);
    @(negedge clk);
    chk("hit_pulse", {31'b0, inst_valid}, 32'd0);

    // conflict on index 0
    miss_fill(32'h0000_1200, 32'h0000_00AA);
    req(32'h0000_1000);
    chk("conflict_remiss", {31'b0, mc_req}, 32'd1);
    resp(32'h0000_1000, 32'h0000_0013, 1'b0);

    // redirect during miss; late return is ignored
    req(32'h0000_2000);
    chk("redir_busy", {31'b0, busy}, 32'd1);
    br = 1'b1;
    @(negedge clk);
    br = 1'b0;
    chk("redir_busy_clr", {31'b0, busy}, 32'd0);
    chk("redir_req_clr", {31'b0, mc_req}, 32'd0);
    resp(32'h0000_2000, 32'h0000_0022, 1'b0);
    chk("redir_no_inst", {31'b0, inst_valid}, 32'd0);
    req(32'h0000_2000);
    chk("redir_not_filled", {31'b0, mc_req}, 32'd1);
    resp(32'h0000_2000, 32'h0000_0022, 1'b0);
    chk("redir_refill", inst, 32'h0000_0022);

    // redirect coinciding with the fill: line written, no instruction
    req(32'h0000_5008);
    resp(32'h0000_5008, 32'h0000_0058, 1'b1);
    chk("brfill_no_inst", {31'b0, inst_valid}, 32'd0);
    req(32'h0000_5008);
    chk("brfill_hit", {31'b0, inst_valid}, 32'd1);
    chk("brfill_inst", inst, 32'h0000_0058);

    // stale return address
    req(32'h0000_4000);
    resp(32'h0000_3000, 32'hDEAD_BEEF, 1'b0);
    chk("stale_req_held", {31'b0, mc_req}, 32'd1);
    chk("stale_no_inst", {31'b0, inst_valid}, 32'd0);
    resp(32'h0000_4000, 32'h0000_0044, 1'b0);
    chk("stale_inst", inst, 32'h0000_0044);

    // back-to-back hits
    miss_fill(32'h0000_1004, 32'h0000_0014);
    miss_fill(32'h0000_100C, 32'h0000_001C);
    if_req = 1'b1; if_pc = 32'h0000_1004;
    @(negedge clk);
    chk("b2b_0", inst, 32'h0000_0014);
    if_pc = 32'h0000_100C;
    @(negedge clk);
    chk("b2b_1", inst, 32'h0000_001C);
    chk("b2b_1_valid", {31'b0, inst_valid}, 32'd1);
    if_pc = 32'h0000_5008;
    @(negedge clk);
    chk("b2b_2", inst, 32'h0000_0058);
    chk("b2b_2_pc", inst_pc, 32'h0000_5008);
    if_req = 1'b0;
    @(negedge clk);

    // I/O space never fills
    for (int n = 0; n < 2; n++) begin
      req(32'h0003_0000);
      chk("io_miss", {31'b0, mc_req}, 32'd1);
      resp(32'h0003_0000, 32'h3000_0001, 1'b0);
      chk("io_inst", inst, 32'h3000_0001);
    end
    req(32'h0000_4000);
    chk("io_kept_line", inst, 32'h0000_0044);

    // pause during a miss
    req(32'h0000_6010);
    rdy = 1'b0; mc_valid = 1'b1; mc_addr_back = 32'h0000_6010; mc_inst = 32'h0000_0061;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("pause_busy", {31'b0, busy}, 32'd1);
      chk("pause_valid", {31'b0, inst_valid}, 32'd0);
    end
    mc_valid = 1'b0; rdy = 1'b1;
    @(negedge clk);
    chk("pause_ignored", {31'b0, mc_req}, 32'd1);
    resp(32'h0000_6010, 32'h0000_0061, 1'b0);
    chk("pause_inst", inst, 32'h0000_0061);

    // asynchronous reset in the middle of a miss
    req(32'h0000_7000);
    chk("prerst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_mc_req", {31'b0, mc_req}, 32'd0);
    chk("arst_mc_addr", mc_addr, 32'd0);
    chk("arst_inst", inst, 32'd0);
    chk("arst_inst_pc", inst_pc, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req(32'h0000_1004);
    chk("postrst_miss", {31'b0, mc_req}, 32'd1);
    resp(32'h0000_1004, 32'h0000_0014, 1'b0);

    // two more misses and two hits since reset
    miss_fill(32'h0000_100C, 32'h0000_001C);
    miss_fill(32'h0000_5008, 32'h0000_0058);
    req(32'h0000_1004);
    chk("stat_hit0", inst, 32'h0000_0014);
    req(32'h0000_100C);
    chk("stat_hit1", inst, 32'h0000_001C);
`ifdef ICACHE_STAT_EN
    chk("stat_hit_cnt", hit_cnt, 32'd2);
    chk("stat_miss_cnt", miss_cnt, 32'd3);
`endif
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
